// File: rtl/uart_tx_dev.sv
// uart_tx_dev: bus-slave UART transmitter. It has a byte FIFO and sends 8N1 frames (8E1/8O1 when UART_TX_PARITY_EN is defined) on TXD.
// It raises a level interrupt when the queue has drained.
module uart_tx_dev #(
   parameter int          FIFO_DEPTH = 4,
   parameter logic [15:0] DIV_RESET  = 16'd434
) (
   input  logic        CLK,
   input  logic        RST,
   input  logic [1:0]  Addr,
   input  logic        WE,
   input  logic [31:0] WD,
   output logic [31:0] RD,
   output logic        IRQ,
   output logic        TXD
);
   localparam int AW = $clog2(FIFO_DEPTH);
   localparam int CW = AW + 1;
   localparam logic [2:0] IDLE   = 3'd0;
   localparam logic [2:0] START  = 3'd1;
   localparam logic [2:0] DATA   = 3'd2;
   localparam logic [2:0] PARITY = 3'd3;
   localparam logic [2:0] STOP   = 3'd4;
`ifdef UART_TX_PARITY_EN
   localparam logic [2:0] AFTER_DATA = PARITY;
`else
   localparam logic [2:0] AFTER_DATA = STOP;
`endif

   logic [2:0]    state;
   logic          en, im, odd, ovf, done, par;
   logic [15:0]   div, per, nper, cnt;
   logic [7:0]    mem [FIFO_DEPTH];
   logic [AW-1:0] wp, rp;
   logic [CW-1:0] count;
   logic [7:0]    sh;
   logic [2:0]    bidx;
   logic          wr_ctrl, push, push_ok, pop, full, bit_end, done_set;
   logic          unused_wd;

   assign unused_wd = ^{WD[31:16], WD[2]};
   assign wr_ctrl   = WE && Addr == 2'd0;
   assign push      = WE && Addr == 2'd1;
   assign full      = count == CW'(FIFO_DEPTH);
   assign pop       = state == IDLE && en && count != '0;
   assign push_ok   = push && (!full || pop);
   assign nper      = div == 16'd0 ? 16'd1 : div;
   assign bit_end   = cnt == per - 16'd1;
   assign done_set  = state == STOP && bit_end && count == '0 && !push;

   assign TXD = state == START  ? 1'b0 :
                state == DATA   ? sh[0] :
                state == PARITY ? par ^ odd : 1'b1;
   assign IRQ = im & done;
   assign RD  = Addr == 2'd0 ? {25'b0, done, ovf, state != IDLE, 1'b0, odd, im, en} :
                Addr == 2'd1 ? {{(32-CW){1'b0}}, count} :
                Addr == 2'd2 ? {16'b0, div} : 32'h0;

   // control fields, sticky overflow/drain flags and the bit divisor
   always_ff @(posedge CLK or negedge RST)
      if (!RST) begin
         en   <= 1'b0;
         im   <= 1'b0;
         ovf  <= 1'b0;
         done <= 1'b0;
         div  <= DIV_RESET;
      end else begin
         if (wr_ctrl) begin
            en <= WD[0];
            im <= WD[1];
         end
         if (WE && Addr == 2'd2) div <= WD[15:0];
         ovf  <= wr_ctrl ? 1'b0 : ovf | (push && !push_ok);
         done <= (wr_ctrl || push) ? 1'b0 : done | done_set;
      end

`ifdef UART_TX_PARITY_EN
   // parity sense and the parity of the byte in flight, captured as it leaves the FIFO
   always_ff @(posedge CLK or negedge RST)
      if (!RST) begin
         odd <= 1'b0;
         par <= 1'b0;
      end else begin
         if (wr_ctrl) odd <= WD[2];
         if (pop) par <= ^mem[rp];
      end
`else
   assign odd = 1'b0;
   assign par = 1'b0;
`endif

   // FIFO storage; a push into a full FIFO lands in the slot being popped the same cycle
   always_ff @(posedge CLK)
      if (push_ok) mem[wp] <= WD[7:0];

   // FIFO pointers and occupancy
   always_ff @(posedge CLK or negedge RST)
      if (!RST) begin
         wp    <= '0;
         rp    <= '0;
         count <= '0;
      end else begin
         if (push_ok) wp <= wp + AW'(1);
         if (pop) rp <= rp + AW'(1);
         count <= count + CW'(push_ok) - CW'(pop);
      end

   // frame sequencer: the period is latched per bit so DIV writes apply from the next bit
   always_ff @(posedge CLK or negedge RST)
      if (!RST) begin
         state <= IDLE;
         cnt   <= 16'd0;
         per   <= 16'd1;
         sh    <= 8'd0;
         bidx  <= 3'd0;
      end else if (state == IDLE) begin
         if (pop) begin
            state <= START;
            sh    <= mem[rp];
            cnt   <= 16'd0;
            bidx  <= 3'd0;
            per   <= nper;
         end
      end else if (!bit_end) begin
         cnt <= cnt + 16'd1;
      end else begin
         cnt <= 16'd0;
         per <= nper;
         if (state == DATA) begin
            sh   <= sh >> 1;
            bidx <= bidx + 3'd1;
         end
         state <= state == START  ? DATA :
                  state == DATA   ? (bidx == 3'd7 ? AFTER_DATA : DATA) :
                  state == PARITY ? STOP : IDLE;
      end
endmodule

// File: tb/tb_uart_tx_dev.sv
// tb_uart_tx_dev: scoreboard bench for uart_tx_dev. Stimulus queues the frames it expects to see on TXD.
// A monitor decodes TXD and compares each bit against the queued frames.
module tb_uart_tx_dev;
   typedef struct packed {
      logic [7:0]        d;
      logic              hp;
      logic              pv;
      logic [10:0][15:0] p;
   } exp_t;

   logic        CLK = 1'b0, RST = 1'b0, WE = 1'b0;
   logic [1:0]  Addr = 2'd0;
   logic [31:0] WD = 32'd0, RD;
   logic        IRQ, TXD;
   int          n_chk = 0, n_fail = 0, cyc = 0, frames_done = 0, n_exp = 0;
   logic        mon_en = 1'b0;
   exp_t        q[$];
   int          starts[$];

   uart_tx_dev dut (.CLK(CLK), .RST(RST), .Addr(Addr), .WE(WE), .WD(WD), .RD(RD), .IRQ(IRQ), .TXD(TXD));

   always #5 CLK = ~CLK;
   always @(posedge CLK) cyc <= cyc + 1;

   function automatic exp_t mk(input logic [7:0] d, input int p, input logic hp, input logic pv);
      exp_t e;
      e.d = d;
      e.hp = hp;
      e.pv = pv;
      for (int i = 0; i < 11; i++) e.p[i] = 16'(p);
      return e;
   endfunction

   task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] exp);
      n_chk++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s got=%h exp=%h", nm, got, exp);
      end
   endtask

   task automatic chk_rd(input logic [1:0] a, input logic [31:0] exp, input string nm);
      Addr = a;
      #1;
      chk(nm, RD, exp);
   endtask

   task automatic wr(input logic [1:0] a, input logic [31:0] d);
      Addr = a;
      WD = d;
      WE = 1'b1;
      @(negedge CLK);
      WE = 1'b0;
   endtask

   task automatic send(input exp_t e);
      q.push_back(e);
      n_exp++;
      wr(2'd1, {24'd0, e.d});
   endtask

   task automatic wait_frames();
      int k = 0;
      while (frames_done < n_exp && k < 3000) begin
         @(negedge CLK);
         k++;
      end
      chk("frames_complete", frames_done, n_exp);
   endtask

   task automatic chk_gaps(input int base, input int n, input int exp);
      for (int i = base; i < base + n - 1; i++)
         chk("frame_spacing", (i + 1 < starts.size()) ? starts[i+1] - starts[i] : -1, exp);
   endtask

   // monitor: decode each frame on TXD and compare bit by bit with the scoreboard
   initial begin
      exp_t e;
      logic [10:0] bits;
      int nb, k;
      logic bad, gotv;
      forever begin
         @(negedge CLK);
         if (mon_en && TXD === 1'b0) begin
            starts.push_back(cyc);
            n_chk++;
            if (q.size() == 0) begin
               n_fail++;
               $display("FAIL unexpected_frame got=start_bit exp=idle");
               k = 0;
               while (TXD !== 1'b1 && k < 5000) begin
                  @(negedge CLK);
                  k++;
               end
            end else begin
               e = q.pop_front();
               bits = {1'b1, e.hp ? e.pv : 1'b1, e.d, 1'b0};
               nb = e.hp ? 11 : 10;
               for (int j = 0; j < nb; j++) begin
                  bad = 1'b0;
                  gotv = bits[j];
                  for (int c = 0; c < int'(e.p[j]); c++) begin
                     if (j != 0 || c != 0) @(negedge CLK);
                     if (TXD !== bits[j]) begin
                        bad = 1'b1;
                        gotv = TXD;
                     end
                  end
                  n_chk++;
                  if (bad) begin
                     n_fail++;
                     $display("FAIL frame_bit byte=%h bit=%0d got=%b exp=%b", e.d, j, gotv, bits[j]);
                  end
               end
               frames_done++;
            end
         end
      end
   end

   initial begin
      #1000000;
      $display("FAIL watchdog got=timeout exp=finish");
      $fatal(1, "watchdog expired");
   end

   initial begin
      int base;
      exp_t e;
      // reset in the middle of a frame
      repeat (3) @(negedge CLK);
      RST = 1'b1;
      @(negedge CLK);
      wr(2'd0, 32'h3);
      wr(2'd1, 32'h55);
      repeat (20) @(negedge CLK);
      chk("mid_frame_txd", TXD, 0);
      chk_rd(2'd0, 32'h13, "mid_frame_ctrl");
      RST = 1'b0;
      #1;
      chk("reset_txd", TXD, 1);
      chk("reset_irq", IRQ, 0);
      chk_rd(2'd2, 32'd434, "reset_div");
      chk_rd(2'd0, 32'h0, "reset_ctrl");
      @(negedge CLK);
      chk_rd(2'd1, 32'h0, "reset_count");
      RST = 1'b1;
      @(negedge CLK);
      mon_en = 1'b1;
      // one frame at 4 cycles/bit, two-edge latency, DONE afterwards
      wr(2'd2, 32'd4);
      wr(2'd0, 32'h1);
      send(mk(8'hA5, 4, 0, 0));
      chk("latency_before_pop", TXD, 1);
      @(negedge CLK);
      chk("latency_fall", TXD, 0);
      wait_frames();
      @(negedge CLK);
      chk_rd(2'd0, 32'h41, "done_after_stop");
      chk("irq_masked", IRQ, 0);
      // overflow while disabled, then drain with interrupt
      wr(2'd2, 32'd2);
      wr(2'd0, 32'h2);
      for (int i = 1; i <= 4; i++) begin
         q.push_back(mk(8'(i * 8'h11), 2, 0, 0));
         n_exp++;
         wr(2'd1, 32'(i * 8'h11));
      end
      wr(2'd1, 32'h55);
      chk_rd(2'd1, 32'd4, "full_count");
      chk_rd(2'd0, 32'h22, "ovf_set");
      chk("irq_before_drain", IRQ, 0);
      base = starts.size();
      wr(2'd0, 32'h3);
      chk_rd(2'd0, 32'h03, "ovf_cleared");
      wait_frames();
      chk_gaps(base, 4, 21);
      @(negedge CLK);
      chk("irq_after_drain", IRQ, 1);
      chk_rd(2'd0, 32'h43, "ctrl_after_drain");
      wr(2'd0, 32'h3);
      chk("irq_cleared", IRQ, 0);
      // push into a full FIFO on the same edge as a pop
      wr(2'd0, 32'h0);
      for (int i = 1; i <= 4; i++) begin
         q.push_back(mk(8'(8'h60 + i), 2, 0, 0));
         n_exp++;
         wr(2'd1, 32'(8'h60 + i));
      end
      wr(2'd0, 32'h1);
      send(mk(8'h65, 2, 0, 0));
      chk_rd(2'd1, 32'd4, "pushpop_count");
      chk_rd(2'd0, 32'h11, "pushpop_no_ovf");
      wait_frames();
      // DIV=0 gives one cycle per bit; a DIV write mid-bit applies from the next bit
      wr(2'd2, 32'd0);
      send(mk(8'h3C, 1, 0, 0));
      wait_frames();
      wr(2'd2, 32'd4);
      e = mk(8'hC3, 3, 0, 0);
      e.p[0] = 16'd4;
      e.p[1] = 16'd4;
      send(e);
      repeat (6) @(negedge CLK);
      wr(2'd2, 32'd3);
      wait_frames();
      wr(2'd2, 32'd2);
`ifdef UART_TX_PARITY_EN
      // even then odd parity on 8'h07, back-to-back frames of 11P+1
      wr(2'd0, 32'h1);
      send(mk(8'h07, 2, 1, 1));
      wait_frames();
      wr(2'd0, 32'h5);
      base = starts.size();
      send(mk(8'h07, 2, 1, 0));
      send(mk(8'h07, 2, 1, 0));
      wait_frames();
      chk_gaps(base, 2, 23);
      @(negedge CLK);
      chk_rd(2'd0, 32'h45, "odd_readback");
`else
      // ODD is not writable without parity support; frames stay 10P+1
      wr(2'd0, 32'h5);
      chk_rd(2'd0, 32'h01, "odd_ignored");
      base = starts.size();
      send(mk(8'h07, 2, 0, 0));
      send(mk(8'h07, 2, 0, 0));
      wait_frames();
      chk_gaps(base, 2, 21);
`endif
      repeat (20) @(negedge CLK);
      chk("scoreboard_empty", q.size(), 0);
      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end
endmodule
